// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_W = 4;

endpackage

// File: rtl/serial_fs_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module serial_fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// with valid/ready handshakes on both operand and result sides.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter  int unsigned W  = DEF_W,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  state_t        state, state_nx;
  logic [W-1:0]  sa, sb, res;
  logic          brw;
  logic          a_sign, b_sign;
  logic [CW-1:0] cnt;
  logic          cell_d, cell_bo;
  logic          last_bit;

  assign last_bit = (cnt == CW'(W - 1));

  serial_fs_cell u_cell (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (brw),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Handshake outputs decode state only, so no input reaches them combinationally.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      brw    <= 1'b0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa     <= a;
            sb     <= b;
            brw    <= bin;
            a_sign <= a[W-1];
            b_sign <= b[W-1];
            cnt    <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          brw <= cell_bo;
          res <= {cell_d, res[W-1:1]};
          // Counter saturates at W-1 so it never leaves its legal range.
          if (!last_bit) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // brw is only reloaded on accept, so it doubles as the held final borrow.
  assign diff = res;
  assign bout = brw;
  assign ovf  = (a_sign != b_sign) && (res[W-1] != a_sign);

endmodule
